// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Holds the FSM state encoding, coin values, the credit ceiling and a
// helper that decides whether a coin still fits into the credit register.
package vend_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CREDIT = 2'd1,
      S_VEND   = 2'd2,
      S_CHANGE = 2'd3
   } state_t;

   localparam logic [3:0] COIN1_VAL  = 4'd1;
   localparam logic [3:0] COIN5_VAL  = 4'd5;
   localparam logic [3:0] MAX_CREDIT = 4'd15;

   // The sum is formed one bit wider so a carry out of the 4-bit credit
   // cannot wrap around and look like a small, acceptable total.
   function automatic logic coin_fits(input logic [3:0] credit, input logic [3:0] value);
      logic [4:0] sum_s;
      sum_s = {1'b0, credit} + {1'b0, value};
      return (sum_s <= {1'b0, MAX_CREDIT});
   endfunction

endpackage

// File: rtl/vend_credit_ctrl_display_scan_div.sv
// Scan clock generator for the two-digit multiplexed display.
// A free-running counter wraps every SCAN_HALF cycles and toggles
// display_clk on each wrap, giving a period of 2*SCAN_HALF clk cycles.
module display_scan_div #(
   parameter int SCAN_HALF = 25_000
) (
   input  logic clk,
   input  logic rst,
   output logic display_clk
);

   localparam int CNT_W = (SCAN_HALF > 1) ? $clog2(SCAN_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_HALF - 1);

   logic [CNT_W-1:0] scan_cnt_r;
   logic             scan_clk_r;

   // Count 0..SCAN_HALF-1 and flip the scan clock whenever the count wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_r <= '0;
         scan_clk_r <= 1'b0;
      end else if (scan_cnt_r == CNT_LAST) begin
         scan_cnt_r <= '0;
         scan_clk_r <= ~scan_clk_r;
      end else begin
         scan_cnt_r <= scan_cnt_r + CNT_W'(1);
      end
   end

   assign display_clk = scan_clk_r;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending-machine credit controller.
// Accumulates coin credit (0..15), vends on buy when the credit covers the
// price, and pays back remaining credit one unit at a time. The credit
// register feeds the display stage directly; a separate divider produces
// the display scan clock.
module vend_credit_ctrl
   import vend_pkg::*;
#(
   parameter int PRICE     = 6,
   parameter int DISP_HOLD = 10_000_000,
   parameter int CHG_GAP   = 5_000_000,
   parameter int SCAN_HALF = 25_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin1,
   input  logic       coin5,
   input  logic       buy,
   input  logic       cancel,
   output logic [3:0] display_num,
   output logic       display_clk,
   output logic       dispense,
   output logic       change_out,
   output logic       coin_reject,
   output logic       busy
);

   localparam int HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
   localparam int GAP_W  = (CHG_GAP > 1) ? $clog2(CHG_GAP) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DISP_HOLD - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CHG_GAP - 1);
   localparam logic [3:0]        PRICE_V   = 4'(PRICE);

   state_t            state_r;
   logic [3:0]        credit_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [GAP_W-1:0]  gap_cnt_r;
   logic              dispense_r;
   logic              change_r;
   logic              reject_r;
   logic              busy_r;

   // Credit FSM: all state, counters and outputs are updated together here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         credit_r   <= 4'd0;
         hold_cnt_r <= '0;
         gap_cnt_r  <= '0;
         dispense_r <= 1'b0;
         change_r   <= 1'b0;
         reject_r   <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         // Pulse outputs fall back to zero unless a branch below raises them.
         change_r <= 1'b0;
         reject_r <= 1'b0;
         case (state_r)
            S_IDLE, S_CREDIT: begin
               // An ignored cancel (no credit) or an unaffordable buy does
               // not use up the cycle, so coins are still evaluated.
               if (cancel && (state_r == S_CREDIT)) begin
                  state_r   <= S_CHANGE;
                  busy_r    <= 1'b1;
                  gap_cnt_r <= '0;
                  reject_r  <= coin1 | coin5;
               end else if (buy && (credit_r >= PRICE_V)) begin
                  credit_r   <= credit_r - PRICE_V;
                  state_r    <= S_VEND;
                  busy_r     <= 1'b1;
                  dispense_r <= 1'b1;
                  hold_cnt_r <= '0;
                  reject_r   <= coin1 | coin5;
               end else if (coin5) begin
                  // A 1-unit coin arriving alongside a 5-unit coin is always refused.
                  if (coin_fits(credit_r, COIN5_VAL)) begin
                     credit_r <= credit_r + COIN5_VAL;
                     state_r  <= S_CREDIT;
                     reject_r <= coin1;
                  end else begin
                     reject_r <= 1'b1;
                  end
               end else if (coin1) begin
                  if (coin_fits(credit_r, COIN1_VAL)) begin
                     credit_r <= credit_r + COIN1_VAL;
                     state_r  <= S_CREDIT;
                  end else begin
                     reject_r <= 1'b1;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            S_VEND: begin
               reject_r <= coin1 | coin5;
               if (hold_cnt_r == HOLD_LAST) begin
                  dispense_r <= 1'b0;
                  hold_cnt_r <= '0;
                  gap_cnt_r  <= '0;
                  if (credit_r != 4'd0) begin
                     state_r <= S_CHANGE;
                  end else begin
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end
            end
            S_CHANGE: begin
               reject_r <= coin1 | coin5;
               if (credit_r == 4'd0) begin
                  // Defensive exit: nothing left to return.
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end else if (gap_cnt_r == GAP_LAST) begin
                  change_r  <= 1'b1;
                  credit_r  <= credit_r - COIN1_VAL;
                  gap_cnt_r <= '0;
                  if (credit_r == COIN1_VAL) begin
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= S_CHANGE;
                  end
               end else begin
                  gap_cnt_r <= gap_cnt_r + GAP_W'(1);
               end
            end
            default: begin
               state_r    <= S_IDLE;
               credit_r   <= 4'd0;
               dispense_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   display_scan_div #(
      .SCAN_HALF (SCAN_HALF)
   ) u_scan_div (
      .clk         (clk),
      .rst         (rst),
      .display_clk (display_clk)
   );

   assign display_num = credit_r;
   assign dispense    = dispense_r;
   assign change_out  = change_r;
   assign coin_reject = reject_r;
   assign busy        = busy_r;

endmodule
